// File: rtl/dice_turn_ctrl.sv
// ----------------------------------------------------------------------------
// dice_turn_ctrl
//   Two-player dice game sequencer. The player whose turn it is holds a key
//   to spin the die and releases it to latch the face. Each face is added to
//   that player's score. The first player to reach WIN_SCORE ends the game.
//   A registered copy of pause freezes the external key debouncers.
// ----------------------------------------------------------------------------
module dice_turn_ctrl #(
    parameter int TICK_DIV  = 2_500_000, // clk cycles per animation step (>=2)
    parameter int MIN_STEPS = 20,        // animation steps before a roll may latch (>=1)
    parameter int WIN_SCORE = 30         // winning score threshold (1..255)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause,
    input  logic       new_game,
    input  logic       btn_p0,
    input  logic       btn_p1,
    output logic       db_stop,
    output logic [2:0] die_value,
    output logic       rolling,
    output logic       turn,
    output logic [7:0] score0,
    output logic [7:0] score1,
    output logic       game_over,
    output logic       winner
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(MIN_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL  = 2'd1,
        SCORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] step_cnt;
    logic          early;
    logic [1:0]    btn_d;
    // Low only until the first clock after reset. While low, the history is
    // loaded with the current key levels so a key held through reset is not
    // taken as a press.
    logic          primed;

    logic [1:0]    btn_now;
    logic [1:0]    press_vec;
    logic [1:0]    release_vec;
    logic          sel_press;
    logic          sel_release;
    logic          tick_wrap;
    logic          steps_done;
    logic [2:0]    next_die;
    logic [7:0]    cur_score;
    logic [8:0]    sum9;
    logic [7:0]    new_score;
    logic          win_hit;

    assign btn_now = {btn_p1, btn_p0};

    // rolling is a plain decode of the state register.
    assign rolling = (state == ROLL);

    // Edge detection, turn selection, animation and score arithmetic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        press_vec   = 2'b00;
        release_vec = 2'b00;
        if (primed) begin
            press_vec   = btn_now & ~btn_d;
            release_vec = ~btn_now & btn_d;
        end
        // Only the key of the player on turn is acted on.
        sel_press   = turn ? press_vec[1]   : press_vec[0];
        sel_release = turn ? release_vec[1] : release_vec[0];

        tick_wrap  = (tick_cnt == TW'(TICK_DIV - 1));
        steps_done = (step_cnt >= SW'(MIN_STEPS));
        next_die   = (die_value == 3'd6) ? 3'd1 : die_value + 3'd1;

        cur_score = turn ? score1 : score0;
        sum9      = {1'b0, cur_score} + {6'd0, die_value};
        new_score = sum9[8] ? 8'hFF : sum9[7:0];
        win_hit   = (new_score >= 8'(WIN_SCORE));
    end

    // Game FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update together from the pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            step_cnt  <= '0;
            early     <= 1'b0;
            btn_d     <= 2'b00;
            primed    <= 1'b0;
            die_value <= 3'd1;
            turn      <= 1'b0;
            score0    <= 8'd0;
            score1    <= 8'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            db_stop   <= 1'b0;
        end else if (new_game) begin
            // new_game wins over pause and aborts any roll in flight.
            state     <= IDLE;
            tick_cnt  <= '0;
            step_cnt  <= '0;
            early     <= 1'b0;
            btn_d     <= btn_now;
            primed    <= 1'b1;
            die_value <= 3'd1;
            turn      <= 1'b0;
            score0    <= 8'd0;
            score1    <= 8'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            db_stop   <= 1'b0;
        end else begin
            db_stop <= pause;

            // History holds through pause so edges made while paused are
            // seen on the first resumed cycle.
            if (!primed) begin
                btn_d  <= btn_now;
                primed <= 1'b1;
            end else if (!pause) begin
                btn_d <= btn_now;
            end

            if (!pause) begin
                unique case (state)
                    IDLE: begin
                        if (sel_press) begin
                            state    <= ROLL;
                            tick_cnt <= '0;
                            step_cnt <= '0;
                            early    <= 1'b0;
                        end
                    end

                    ROLL: begin
                        // Animation keeps running on the cycle that leaves
                        // ROLL; the face shown on entry to SCORE is scored.
                        if (tick_wrap) begin
                            tick_cnt  <= '0;
                            die_value <= next_die;
                            if (!steps_done) begin
                                step_cnt <= step_cnt + SW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end

                        if ((sel_release || early) && steps_done) begin
                            state <= SCORE;
                        end else if (sel_release) begin
                            // Released too soon: remember it and latch as
                            // soon as the minimum step count is reached.
                            early <= 1'b1;
                        end
                    end

                    SCORE: begin
                        if (turn) begin
                            score1 <= new_score;
                        end else begin
                            score0 <= new_score;
                        end

                        if (win_hit) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                            winner    <= turn;
                        end else begin
                            state <= IDLE;
                            turn  <= ~turn;
                        end
                    end

                    DONE: begin
                        // Game finished; only new_game or reset leaves here.
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
